// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MIPS64 memory-access stage: control-bus bit
// indices, access-size encodings, FSM state encodings and lane helpers.
package mem_access_stage_pkg;

  localparam int MA_CTRL_BITS  = 6;

  localparam int CTL_MEM_READ  = 0;
  localparam int CTL_MEM_WRITE = 1;
  localparam int CTL_SIZE_LO   = 2;
  localparam int CTL_SIGN_EXT  = 4;
  localparam int CTL_REG_WRITE = 5;

  localparam logic [1:0] MA_SZ_B = 2'd0;
  localparam logic [1:0] MA_SZ_H = 2'd1;
  localparam logic [1:0] MA_SZ_W = 2'd2;
  localparam logic [1:0] MA_SZ_D = 2'd3;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  // Low address bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] size_mask(input logic [1:0] size);
    case (size)
      MA_SZ_B: size_mask = 3'b000;
      MA_SZ_H: size_mask = 3'b001;
      MA_SZ_W: size_mask = 3'b011;
      default: size_mask = 3'b111;
    endcase
  endfunction

  function automatic logic [7:0] size_base_en(input logic [1:0] size);
    case (size)
      MA_SZ_B: size_base_en = 8'h01;
      MA_SZ_H: size_base_en = 8'h03;
      MA_SZ_W: size_base_en = 8'h0F;
      default: size_base_en = 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/ma_lane_align.sv
// Little-endian lane steering for the memory-access stage: byte enables,
// store-data shifting and load extraction with sign/zero extension.
module ma_lane_align
  import mem_access_stage_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [2:0]       off_raw,
  input  logic [1:0]       size,
  input  logic             sign_ext,
  input  logic [WIDTH-1:0] st_data,
  input  logic [WIDTH-1:0] rd_data,
  output logic [7:0]       byte_en,
  output logic [WIDTH-1:0] st_lane,
  output logic [WIDTH-1:0] ld_data
);

  logic [2:0]       off;
  logic [WIDTH-1:0] rd_shift;

  always_comb begin
    // Misaligned offsets are rounded down to the access size boundary.
    off      = off_raw & ~size_mask(size);
    byte_en  = size_base_en(size) << off;
    st_lane  = st_data << {off, 3'b000};
    rd_shift = rd_data >> {off, 3'b000};
    ld_data  = rd_shift;
    case (size)
      MA_SZ_B: ld_data = {{(WIDTH-8){sign_ext & rd_shift[7]}}, rd_shift[7:0]};
      MA_SZ_H: ld_data = {{(WIDTH-16){sign_ext & rd_shift[15]}}, rd_shift[15:0]};
      MA_SZ_W: ld_data = {{(WIDTH-32){sign_ext & rd_shift[31]}}, rd_shift[31:0]};
      default: ld_data = rd_shift;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MIPS64 memory-access stage: IDLE/BUSY FSM driving a req/ack data-memory port
// and registered write-back outputs. Optional feature: MA_MISALIGN_CHECK_EN.
// Handshake: p_DM_Req stays high with We/Addr/WData/ByteEn stable until the
// cycle p_DM_Ack is seen; upstream is held (p_MA_Stall) for every BUSY cycle.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int WIDTH        = 64,
  parameter int ADDR         = 5,
  parameter int MA_CTRL_SIZE = MA_CTRL_BITS
) (
  input  logic                    p_clk,
  input  logic                    p_reset,
  input  logic                    p_MA_Valid,
  input  logic [MA_CTRL_SIZE-1:0] p_MA_Ctrl_Bus,
  input  logic [WIDTH-1:0]        p_MA_ALUResult,
  input  logic [WIDTH-1:0]        p_MA_WriteData,
  input  logic [ADDR-1:0]         p_MA_WriteAddress,
  output logic                    p_MA_Stall,
  output logic                    p_DM_Req,
  output logic                    p_DM_We,
  output logic [WIDTH-1:0]        p_DM_Addr,
  output logic [WIDTH-1:0]        p_DM_WData,
  output logic [7:0]              p_DM_ByteEn,
  input  logic                    p_DM_Ack,
  input  logic [WIDTH-1:0]        p_DM_RData,
  output logic                    p_MA_WB_Valid,
  output logic                    p_MA_WB_RegWrite,
  output logic [WIDTH-1:0]        p_MA_WB_Data,
  output logic [ADDR-1:0]         p_MA_WB_Addr,
`ifdef MA_MISALIGN_CHECK_EN
  output logic                    p_MA_AddrErr,
`endif
  output logic [0:0]              dbg_state
);

  logic [0:0]              state;
  logic [WIDTH-1:0]        cap_addr;
  logic [WIDTH-1:0]        cap_wdata;
  logic [MA_CTRL_SIZE-1:0] cap_ctrl;
  logic [ADDR-1:0]         cap_waddr;
  logic                    busy;
  logic                    in_mem_op;
  logic [7:0]              lane_be;
  logic [WIDTH-1:0]        lane_wdata;
  logic [WIDTH-1:0]        lane_load;

  assign busy      = (state == ST_BUSY);
  assign in_mem_op = p_MA_Ctrl_Bus[CTL_MEM_READ] | p_MA_Ctrl_Bus[CTL_MEM_WRITE];
  assign dbg_state = state;

`ifdef MA_MISALIGN_CHECK_EN
  logic in_misaligned;
  logic addr_err_q;
  assign in_misaligned = (p_MA_ALUResult[2:0] &
                          size_mask(p_MA_Ctrl_Bus[CTL_SIZE_LO +: 2])) != 3'b000;
  assign p_MA_AddrErr  = addr_err_q;
`endif

  ma_lane_align #(.WIDTH(WIDTH)) u_lane (
    .off_raw (cap_addr[2:0]),
    .size    (cap_ctrl[CTL_SIZE_LO +: 2]),
    .sign_ext(cap_ctrl[CTL_SIGN_EXT]),
    .st_data (cap_wdata),
    .rd_data (p_DM_RData),
    .byte_en (lane_be),
    .st_lane (lane_wdata),
    .ld_data (lane_load)
  );

  // Memory port is quiet outside BUSY so reset and idle both present zeros.
  assign p_MA_Stall  = busy;
  assign p_DM_Req    = busy;
  assign p_DM_We     = busy & cap_ctrl[CTL_MEM_WRITE];
  assign p_DM_Addr   = busy ? {cap_addr[WIDTH-1:3], 3'b000} : '0;
  assign p_DM_WData  = busy ? lane_wdata : '0;
  assign p_DM_ByteEn = busy ? lane_be : 8'h00;

  always_ff @(posedge p_clk or posedge p_reset) begin
    if (p_reset) begin
      state            <= ST_IDLE;
      cap_addr         <= '0;
      cap_wdata        <= '0;
      cap_ctrl         <= '0;
      cap_waddr        <= '0;
      p_MA_WB_Valid    <= 1'b0;
      p_MA_WB_RegWrite <= 1'b0;
      p_MA_WB_Data     <= '0;
      p_MA_WB_Addr     <= '0;
`ifdef MA_MISALIGN_CHECK_EN
      addr_err_q       <= 1'b0;
`endif
    end else begin
      p_MA_WB_Valid <= 1'b0;
`ifdef MA_MISALIGN_CHECK_EN
      addr_err_q    <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (p_MA_Valid) begin
            if (!in_mem_op) begin
              p_MA_WB_Valid    <= 1'b1;
              p_MA_WB_RegWrite <= p_MA_Ctrl_Bus[CTL_REG_WRITE];
              p_MA_WB_Data     <= p_MA_ALUResult;
              p_MA_WB_Addr     <= p_MA_WriteAddress;
            end
`ifdef MA_MISALIGN_CHECK_EN
            else if (in_misaligned) begin
              addr_err_q <= 1'b1;
            end
`endif
            else begin
              cap_addr  <= p_MA_ALUResult;
              cap_wdata <= p_MA_WriteData;
              cap_ctrl  <= p_MA_Ctrl_Bus;
              cap_waddr <= p_MA_WriteAddress;
              state     <= ST_BUSY;
            end
          end
        end
        default: begin
          if (p_DM_Ack) begin
            p_MA_WB_Valid    <= 1'b1;
            p_MA_WB_RegWrite <= cap_ctrl[CTL_REG_WRITE];
            p_MA_WB_Data     <= cap_ctrl[CTL_MEM_READ] ? lane_load : cap_addr;
            p_MA_WB_Addr     <= cap_waddr;
            state            <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: byte-level reference model,
// per-cycle compare process and directed plus randomized stimulus.
module tb_mem_access_stage;

  logic        p_clk;
  logic        p_reset;
  logic        p_MA_Valid;
  logic [5:0]  p_MA_Ctrl_Bus;
  logic [63:0] p_MA_ALUResult;
  logic [63:0] p_MA_WriteData;
  logic [4:0]  p_MA_WriteAddress;
  logic        p_MA_Stall;
  logic        p_DM_Req;
  logic        p_DM_We;
  logic [63:0] p_DM_Addr;
  logic [63:0] p_DM_WData;
  logic [7:0]  p_DM_ByteEn;
  logic        p_DM_Ack;
  logic [63:0] p_DM_RData;
  logic        p_MA_WB_Valid;
  logic        p_MA_WB_RegWrite;
  logic [63:0] p_MA_WB_Data;
  logic [4:0]  p_MA_WB_Addr;
  logic [0:0]  dbg_state;
`ifdef MA_MISALIGN_CHECK_EN
  logic        p_MA_AddrErr;
`endif

  mem_access_stage dut (
    .p_clk            (p_clk),
    .p_reset          (p_reset),
    .p_MA_Valid       (p_MA_Valid),
    .p_MA_Ctrl_Bus    (p_MA_Ctrl_Bus),
    .p_MA_ALUResult   (p_MA_ALUResult),
    .p_MA_WriteData   (p_MA_WriteData),
    .p_MA_WriteAddress(p_MA_WriteAddress),
    .p_MA_Stall       (p_MA_Stall),
    .p_DM_Req         (p_DM_Req),
    .p_DM_We          (p_DM_We),
    .p_DM_Addr        (p_DM_Addr),
    .p_DM_WData       (p_DM_WData),
    .p_DM_ByteEn      (p_DM_ByteEn),
    .p_DM_Ack         (p_DM_Ack),
    .p_DM_RData       (p_DM_RData),
    .p_MA_WB_Valid    (p_MA_WB_Valid),
    .p_MA_WB_RegWrite (p_MA_WB_RegWrite),
    .p_MA_WB_Data     (p_MA_WB_Data),
    .p_MA_WB_Addr     (p_MA_WB_Addr),
`ifdef MA_MISALIGN_CHECK_EN
    .p_MA_AddrErr     (p_MA_AddrErr),
`endif
    .dbg_state        (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial p_clk = 1'b0;
  always #5 p_clk = ~p_clk;

  // ---------------- scoreboard state ----------------
  typedef struct {
    int          due;
    logic [63:0] data;
    logic [4:0]  addr;
    logic        rw;
  } wb_rec_t;

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  be;
  } req_rec_t;

  wb_rec_t  exp_q[$];
  req_rec_t exp_req;
  logic     exp_busy;
  int       err_due;
  int       ncyc;
  int       stall_cnt;
  int       tests;
  int       fails;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (byte level) ----------------
  function automatic logic [2:0] model_off(input logic [2:0] a, input logic [1:0] sz);
    int n;
    n = 1 << sz;
    return 3'(int'(a) - (int'(a) % n));
  endfunction

  function automatic logic [7:0] model_be(input logic [2:0] off, input logic [1:0] sz);
    logic [7:0] be;
    int n;
    n = 1 << sz;
    for (int i = 0; i < 8; i++) be[i] = (i >= int'(off)) && (i < int'(off) + n);
    return be;
  endfunction

  function automatic logic [63:0] model_wdata(input logic [63:0] d, input logic [2:0] off);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 8; i++)
      if (i >= int'(off)) r[8*i +: 8] = d[8*(i-int'(off)) +: 8];
    return r;
  endfunction

  function automatic logic [63:0] model_load(input logic [63:0] rd, input logic [2:0] off,
                                             input logic [1:0] sz, input logic sx);
    logic [63:0] v;
    int n;
    n = 1 << sz;
    v = '0;
    for (int j = 0; j < n; j++) v[8*j +: 8] = rd[8*(int'(off)+j) +: 8];
    if (sx && n < 8 && v[8*n-1])
      for (int j = n; j < 8; j++) v[8*j +: 8] = 8'hFF;
    return v;
  endfunction

  function automatic logic [5:0] mk_ctrl(input logic rw, input logic sx, input logic [1:0] sz,
                                         input logic mw, input logic mr);
    return {rw, sx, sz, mw, mr};
  endfunction

  task automatic set_req(input logic [5:0] ctrl, input logic [63:0] alu, input logic [63:0] wd);
    logic [2:0] off;
    off = model_off(alu[2:0], ctrl[3:2]);
    exp_req.we    = ctrl[1];
    exp_req.addr  = {alu[63:3], 3'b000};
    exp_req.wdata = model_wdata(wd, off);
    exp_req.be    = model_be(off, ctrl[3:2]);
  endtask

  // ---------------- compare process ----------------
  always @(negedge p_clk) begin
    ncyc++;
    if (p_MA_Stall) stall_cnt++;
    if (!p_reset) begin
      check("stall", {63'b0, p_MA_Stall}, {63'b0, exp_busy});
      check("req", {63'b0, p_DM_Req}, {63'b0, exp_busy});
      if (exp_busy) begin
        check("dm_we", {63'b0, p_DM_We}, {63'b0, exp_req.we});
        check("dm_addr", p_DM_Addr, exp_req.addr);
        check("dm_wdata", p_DM_WData, exp_req.wdata);
        check("dm_byteen", {56'b0, p_DM_ByteEn}, {56'b0, exp_req.be});
      end
      if (exp_q.size() > 0 && exp_q[0].due == ncyc) begin
        check("wb_valid", {63'b0, p_MA_WB_Valid}, 64'd1);
        check("wb_data", p_MA_WB_Data, exp_q[0].data);
        check("wb_addr", {59'b0, p_MA_WB_Addr}, {59'b0, exp_q[0].addr});
        check("wb_regwrite", {63'b0, p_MA_WB_RegWrite}, {63'b0, exp_q[0].rw});
        void'(exp_q.pop_front());
      end else begin
        check("wb_valid_idle", {63'b0, p_MA_WB_Valid}, 64'd0);
      end
`ifdef MA_MISALIGN_CHECK_EN
      check("addr_err", {63'b0, p_MA_AddrErr}, {63'b0, (err_due == ncyc)});
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [5:0] ctrl, input logic [63:0] alu, input logic [63:0] wd,
                       input logic [4:0] wa, input int delay, input logic [63:0] rd);
    logic [2:0] off;
    @(negedge p_clk);
    p_MA_Valid        = 1'b1;
    p_MA_Ctrl_Bus     = ctrl;
    p_MA_ALUResult    = alu;
    p_MA_WriteData    = wd;
    p_MA_WriteAddress = wa;
    @(posedge p_clk);
    #1;
    p_MA_Valid = 1'b0;
    if (!(ctrl[0] | ctrl[1])) begin
      exp_q.push_back('{due: ncyc + 1, data: alu, addr: wa, rw: ctrl[5]});
      return;
    end
`ifdef MA_MISALIGN_CHECK_EN
    if ((int'(alu[2:0]) % (1 << ctrl[3:2])) != 0) begin
      err_due = ncyc + 1;
      return;
    end
`endif
    off = model_off(alu[2:0], ctrl[3:2]);
    set_req(ctrl, alu, wd);
    exp_busy = 1'b1;
    for (int k = 1; k <= delay; k++) begin
      @(negedge p_clk);
      // Upstream noise while busy must be ignored.
      p_MA_Valid        = 1'($urandom_range(0, 1));
      p_MA_Ctrl_Bus     = 6'($urandom);
      p_MA_ALUResult    = {$urandom, $urandom};
      p_MA_WriteAddress = 5'($urandom);
      p_DM_Ack          = (k == delay);
      p_DM_RData        = (k == delay) ? rd : {$urandom, $urandom};
      @(posedge p_clk);
      #1;
    end
    p_DM_Ack   = 1'b0;
    p_MA_Valid = 1'b0;
    exp_busy   = 1'b0;
    exp_q.push_back('{due: ncyc + 1,
                      data: ctrl[0] ? model_load(rd, off, ctrl[3:2], ctrl[4]) : alu,
                      addr: wa, rw: ctrl[5]});
  endtask

  task automatic idle_cycle();
    @(negedge p_clk);
    p_MA_Valid = 1'b0;
    p_DM_Ack   = 1'($urandom_range(0, 1));
    p_DM_RData = {$urandom, $urandom};
    @(posedge p_clk);
    #1;
    p_DM_Ack = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int s0;
    logic [1:0] sz;
    logic mem, st;
    exp_busy = 1'b0; err_due = -1; ncyc = 0; stall_cnt = 0; tests = 0; fails = 0;
    p_reset = 1'b1; p_MA_Valid = 1'b0; p_MA_Ctrl_Bus = '0; p_MA_ALUResult = '0;
    p_MA_WriteData = '0; p_MA_WriteAddress = '0; p_DM_Ack = 1'b0; p_DM_RData = '0;

    repeat (3) @(negedge p_clk);
    check("rst_stall", {63'b0, p_MA_Stall}, 64'd0);
    check("rst_req", {63'b0, p_DM_Req}, 64'd0);
    check("rst_wb_valid", {63'b0, p_MA_WB_Valid}, 64'd0);
    check("rst_wb_data", p_MA_WB_Data, 64'd0);
    check("rst_dm_addr", p_DM_Addr, 64'd0);
    check("rst_byteen", {56'b0, p_DM_ByteEn}, 64'd0);
    p_reset = 1'b0;

    // Pin the model against hand-computed values.
    check("pin_lb_data", model_load(64'h00000000_80000000, 3'd3, 2'd0, 1'b1), 64'hFFFF_FFFF_FFFF_FF80);
    check("pin_lb_be", {56'b0, model_be(3'd3, 2'd0)}, 64'h08);
    check("pin_sh_be", {56'b0, model_be(3'd6, 2'd1)}, 64'hC0);
    check("pin_sh_wdata", model_wdata(64'hBEEF, 3'd6), 64'hBEEF_0000_0000_0000);
    check("pin_lwu_data", model_load(64'hF000_0001_DEAD_BEEF, 3'd4, 2'd2, 1'b0), 64'h0000_0000_F000_0001);
    check("pin_ld_be", {56'b0, model_be(3'd0, 2'd3)}, 64'hFF);
`ifndef MA_MISALIGN_CHECK_EN
    check("pin_ld_force_align", {61'b0, model_off(3'd2, 2'd3)}, 64'd0);
`endif

    // Directed cases.
    issue(mk_ctrl(1, 0, 2'd0, 0, 0), 64'h1234, 64'h0, 5'd7, 0, 64'h0);
    s0 = stall_cnt;
    issue(mk_ctrl(1, 1, 2'd0, 0, 1), 64'h0000_0000_0000_1003, 64'h0, 5'd3, 3, 64'h00000000_80000000);
    check("lb_stall_cycles", 64'(stall_cnt - s0), 64'd3);
    issue(mk_ctrl(0, 0, 2'd1, 1, 0), 64'h0000_0000_0000_2006, 64'hBEEF, 5'd0, 1, 64'h0);
    issue(mk_ctrl(1, 0, 2'd2, 0, 1), 64'h0000_0000_0000_3004, 64'h0, 5'd9, 2, 64'hF000_0001_DEAD_BEEF);
    issue(mk_ctrl(1, 0, 2'd3, 0, 1), 64'h0000_0000_0000_4002, 64'h0, 5'd11, 1, 64'h0123_4567_89AB_CDEF);
    issue(mk_ctrl(1, 0, 2'd0, 0, 0), 64'hAAAA, 64'h0, 5'd1, 0, 64'h0);
    issue(mk_ctrl(0, 0, 2'd0, 0, 0), 64'hBBBB, 64'h0, 5'd2, 0, 64'h0);

    // Reset while a load is outstanding.
    @(negedge p_clk);
    p_MA_Valid = 1'b1; p_MA_Ctrl_Bus = mk_ctrl(1, 0, 2'd3, 0, 1);
    p_MA_ALUResult = 64'h5000; p_MA_WriteAddress = 5'd4;
    @(posedge p_clk); #1;
    p_MA_Valid = 1'b0;
    set_req(mk_ctrl(1, 0, 2'd3, 0, 1), 64'h5000, 64'h0);
    exp_busy = 1'b1;
    repeat (2) @(posedge p_clk);
    #1;
    p_reset = 1'b1;
    exp_busy = 1'b0;
    #1;
    check("midrst_req", {63'b0, p_DM_Req}, 64'd0);
    check("midrst_stall", {63'b0, p_MA_Stall}, 64'd0);
    check("midrst_wb_valid", {63'b0, p_MA_WB_Valid}, 64'd0);
    check("midrst_byteen", {56'b0, p_DM_ByteEn}, 64'd0);
    @(negedge p_clk);
    p_reset = 1'b0;
    issue(mk_ctrl(1, 1, 2'd1, 0, 1), 64'h5008, 64'h0, 5'd5, 2, 64'h0000_0000_0000_8001);

    // Randomized traffic.
    for (int t = 0; t < 200; t++) begin
      sz  = 2'($urandom_range(0, 3));
      mem = ($urandom_range(0, 9) < 6);
      st  = 1'($urandom_range(0, 1));
      if (!mem)
        issue(mk_ctrl(1'($urandom), 1'($urandom), sz, 0, 0), {$urandom, $urandom},
              {$urandom, $urandom}, 5'($urandom), 0, 64'h0);
      else if (st)
        issue(mk_ctrl(0, 1'($urandom), sz, 1, 0), {$urandom, $urandom},
              {$urandom, $urandom}, 5'($urandom), $urandom_range(1, 4), 64'h0);
      else
        issue(mk_ctrl(1, 1'($urandom), sz, 0, 1), {$urandom, $urandom},
              {$urandom, $urandom}, 5'($urandom), $urandom_range(1, 4), {$urandom, $urandom});
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end

    repeat (3) @(negedge p_clk);
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
